// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control FSM.
// State enum, opcode constants, mux-select encodings, control bundle.
// Optional: CTRL_BNE_EN makes opcode 000101 (bne) a legal branch.
`timescale 1ns/1ps
package mips_ctrl_pkg;

   localparam int OPW_D = 6;
   localparam int SW_D  = 4;

   typedef enum logic [SW_D-1:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_MEMADR = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWB  = 4'd5,
      S_MEMWR  = 4'd6,
      S_EXEC   = 4'd7,
      S_ALUWB  = 4'd8,
      S_BRANCH = 4'd9,
      S_ADDIEX = 4'd10,
      S_ADDIWB = 4'd11,
      S_JUMP   = 4'd12
   } state_e;

   localparam logic [OPW_D-1:0] OP_LW   = 6'b100011;
   localparam logic [OPW_D-1:0] OP_SW   = 6'b101011;
   localparam logic [OPW_D-1:0] OP_RTYP = 6'b000000;
   localparam logic [OPW_D-1:0] OP_BEQ  = 6'b000100;
   localparam logic [OPW_D-1:0] OP_BNE  = 6'b000101;
   localparam logic [OPW_D-1:0] OP_ADDI = 6'b001000;
   localparam logic [OPW_D-1:0] OP_J    = 6'b000010;

   localparam logic [1:0] SRCB_REG   = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pc_en;
      logic       iord;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_src;
      logic       illegal_op;
   } ctrl_t;

   function automatic logic op_legal(input logic [OPW_D-1:0] op);
      logic ok;
      ok = (op == OP_LW) || (op == OP_SW) ||
           (op == OP_RTYP) || (op == OP_BEQ) ||
           (op == OP_ADDI) || (op == OP_J);
`ifdef CTRL_BNE_EN
      ok = ok || (op == OP_BNE);
`endif
      return ok;
   endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational state-to-control decoder for the multicycle MIPS FSM.
// In: state_i, opcode_i, mem_ready_i, zero_i. Out: ctrl_o bundle. Macro CTRL_BNE_EN.
`timescale 1ns/1ps
module multicycle_ctrl_decode
   import mips_ctrl_pkg::*;
(
   input  state_e           state_i,
   input  logic [OPW_D-1:0] opcode_i,
   input  logic             mem_ready_i,
   input  logic             zero_i,
   output ctrl_t            ctrl_o
);

   always_comb begin
      ctrl_o = '0;
      unique case (state_i)
         S_IDLE: ;
         S_FETCH: begin
            ctrl_o.alu_src_b = SRCB_FOUR;
            ctrl_o.ir_write  = mem_ready_i;
            ctrl_o.pc_en     = mem_ready_i;
         end
         S_DECODE: begin
            ctrl_o.alu_src_b  = SRCB_IMMSH;
            ctrl_o.illegal_op = !op_legal(opcode_i);
         end
         S_MEMADR, S_ADDIEX: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRCB_IMM;
         end
         S_MEMRD: ctrl_o.iord = 1'b1;
         S_MEMWB: begin
            ctrl_o.mem_to_reg = 1'b1;
            ctrl_o.reg_write  = 1'b1;
         end
         S_MEMWR: begin
            ctrl_o.iord      = 1'b1;
            ctrl_o.mem_write = 1'b1;
         end
         S_EXEC: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_op    = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            ctrl_o.reg_dst   = 1'b1;
            ctrl_o.reg_write = 1'b1;
         end
         S_BRANCH: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_op    = ALUOP_SUB;
            ctrl_o.pc_src    = PCSRC_ALUOUT;
`ifdef CTRL_BNE_EN
            // bne takes the branch when the compare is not equal
            ctrl_o.pc_en = zero_i ^ (opcode_i == OP_BNE);
`else
            ctrl_o.pc_en = zero_i;
`endif
         end
         S_ADDIWB: ctrl_o.reg_write = 1'b1;
         S_JUMP: begin
            ctrl_o.pc_src = PCSRC_JUMP;
            ctrl_o.pc_en  = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Moore control FSM for the multicycle MIPS datapath: state register + next state.
// Ports: clk, reset (async low), Opcode/Zero/MemReady in; selects, enables, State out. Macro CTRL_BNE_EN.
`timescale 1ns/1ps
module multicycle_control_fsm
   import mips_ctrl_pkg::*;
#(
   parameter int OPW = OPW_D,
   parameter int SW  = SW_D
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [OPW-1:0] Opcode,
   input  logic           Zero,
   input  logic           MemReady,
   output logic           PCEn,
   output logic           IorD,
   output logic           MemWrite,
   output logic           IRWrite,
   output logic           RegDst,
   output logic           MemtoReg,
   output logic           RegWrite,
   output logic           ALUSrcA,
   output logic [1:0]     ALUSrcB,
   output logic [1:0]     ALUOp,
   output logic [1:0]     PCSrc,
   output logic           IllegalOp,
   output logic [SW-1:0]  State
);

   state_e state_q;
   state_e state_d;
   ctrl_t  ctrl;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = S_FETCH;
      unique case (state_q)
         S_IDLE:  state_d = S_FETCH;
         S_FETCH: state_d = MemReady ? S_DECODE : S_FETCH;
         S_DECODE: begin
            unique case (Opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYP:      state_d = S_EXEC;
               OP_BEQ:       state_d = S_BRANCH;
`ifdef CTRL_BNE_EN
               OP_BNE:       state_d = S_BRANCH;
`endif
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JUMP;
               default:      state_d = S_FETCH;
            endcase
         end
         // Opcode is held stable, so anything not lw here is sw
         S_MEMADR: state_d = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  state_d = MemReady ? S_MEMWB : S_MEMRD;
         S_MEMWB:  state_d = S_FETCH;
         S_MEMWR:  state_d = MemReady ? S_FETCH : S_MEMWR;
         S_EXEC:   state_d = S_ALUWB;
         S_ALUWB:  state_d = S_FETCH;
         S_BRANCH: state_d = S_FETCH;
         S_ADDIEX: state_d = S_ADDIWB;
         S_ADDIWB: state_d = S_FETCH;
         S_JUMP:   state_d = S_FETCH;
         default:  state_d = S_FETCH;
      endcase
   end

   multicycle_ctrl_decode u_dec (
      .state_i     (state_q),
      .opcode_i    (Opcode),
      .mem_ready_i (MemReady),
      .zero_i      (Zero),
      .ctrl_o      (ctrl)
   );

   assign PCEn      = ctrl.pc_en;
   assign IorD      = ctrl.iord;
   assign MemWrite  = ctrl.mem_write;
   assign IRWrite   = ctrl.ir_write;
   assign RegDst    = ctrl.reg_dst;
   assign MemtoReg  = ctrl.mem_to_reg;
   assign RegWrite  = ctrl.reg_write;
   assign ALUSrcA   = ctrl.alu_src_a;
   assign ALUSrcB   = ctrl.alu_src_b;
   assign ALUOp     = ctrl.alu_op;
   assign PCSrc     = ctrl.pc_src;
   assign IllegalOp = ctrl.illegal_op;
   assign State     = SW'(state_q);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed self-checking bench for multicycle_control_fsm.
// Outputs packed as {PCEn,IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSrc,IllegalOp}.
`timescale 1ns/1ps
module tb_multicycle_control_fsm;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [5:0] Opcode = 6'b0;
   logic       Zero = 1'b0;
   logic       MemReady = 1'b0;
   logic       PCEn, IorD, MemWrite, IRWrite;
   logic       RegDst, MemtoReg, RegWrite, ALUSrcA;
   logic [1:0] ALUSrcB, ALUOp, PCSrc;
   logic       IllegalOp;
   logic [3:0] State;
   logic [14:0] outs;

   int checks = 0;
   int errors = 0;

   localparam logic [14:0] V_ZERO = 15'b0;
   localparam logic [14:0] V_F1   = 15'b1_0_0_1_0_0_0_0_01_00_00_0;
   localparam logic [14:0] V_F0   = 15'b0_0_0_0_0_0_0_0_01_00_00_0;
   localparam logic [14:0] V_DEC  = 15'b0_0_0_0_0_0_0_0_11_00_00_0;
   localparam logic [14:0] V_DECI = 15'b0_0_0_0_0_0_0_0_11_00_00_1;
   localparam logic [14:0] V_MADR = 15'b0_0_0_0_0_0_0_1_10_00_00_0;
   localparam logic [14:0] V_MRD  = 15'b0_1_0_0_0_0_0_0_00_00_00_0;
   localparam logic [14:0] V_MWB  = 15'b0_0_0_0_0_1_1_0_00_00_00_0;
   localparam logic [14:0] V_MWR  = 15'b0_1_1_0_0_0_0_0_00_00_00_0;
   localparam logic [14:0] V_EXEC = 15'b0_0_0_0_0_0_0_1_00_10_00_0;
   localparam logic [14:0] V_AWB  = 15'b0_0_0_0_1_0_1_0_00_00_00_0;
   localparam logic [14:0] V_IWB  = 15'b0_0_0_0_0_0_1_0_00_00_00_0;
   localparam logic [14:0] V_BR1  = 15'b1_0_0_0_0_0_0_1_00_01_01_0;
   localparam logic [14:0] V_BR0  = 15'b0_0_0_0_0_0_0_1_00_01_01_0;
   localparam logic [14:0] V_JMP  = 15'b1_0_0_0_0_0_0_0_00_00_10_0;

   multicycle_control_fsm dut (
      .clk       (clk),
      .reset     (reset),
      .Opcode    (Opcode),
      .Zero      (Zero),
      .MemReady  (MemReady),
      .PCEn      (PCEn),
      .IorD      (IorD),
      .MemWrite  (MemWrite),
      .IRWrite   (IRWrite),
      .RegDst    (RegDst),
      .MemtoReg  (MemtoReg),
      .RegWrite  (RegWrite),
      .ALUSrcA   (ALUSrcA),
      .ALUSrcB   (ALUSrcB),
      .ALUOp     (ALUOp),
      .PCSrc     (PCSrc),
      .IllegalOp (IllegalOp),
      .State     (State)
   );

   assign outs = {PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg,
                  RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, IllegalOp};

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      Opcode = 6'b0;
      MemReady = 1'b0;
      Zero = 1'b0;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if ({State, outs} !== {4'd0, V_ZERO}) begin
            errors++;
            $display("FAIL reset_hold[%0d]: state=%0d outs=%b want state=0 outs=%b",
                     i, State, outs, V_ZERO);
         end
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if ({State, outs} !== {4'd0, V_ZERO}) begin
         errors++;
         $display("FAIL reset_release_idle: state=%0d outs=%b want state=0 outs=%b",
                  State, outs, V_ZERO);
      end
      step();
      checks++;
      if ({State, outs} !== {4'd1, V_F0}) begin
         errors++;
         $display("FAIL reset_to_fetch: state=%0d outs=%b want state=1 outs=%b",
                  State, outs, V_F0);
      end
      step();
      checks++;
      if ({State, outs} !== {4'd1, V_F0}) begin
         errors++;
         $display("FAIL fetch_stall: state=%0d outs=%b want state=1 outs=%b",
                  State, outs, V_F0);
      end
      MemReady = 1'b1;
      #1;
      checks++;
      if ({State, outs} !== {4'd1, V_F1}) begin
         errors++;
         $display("FAIL fetch_ready: state=%0d outs=%b want state=1 outs=%b",
                  State, outs, V_F1);
      end
   endtask

   task automatic test_lw();
      bit          mr[6] = '{1, 1, 1, 1, 1, 1};
      int          st[6] = '{1, 2, 3, 4, 5, 1};
      logic [14:0] v[6]  = '{V_F1, V_DEC, V_MADR, V_MRD, V_MWB, V_F1};
      Opcode = 6'b100011;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) step();
         MemReady = mr[i];
         #1;
         checks++;
         if ({State, outs} !== {st[i][3:0], v[i]}) begin
            errors++;
            $display("FAIL lw[%0d]: state=%0d outs=%b want state=%0d outs=%b",
                     i, State, outs, st[i], v[i]);
         end
      end
   endtask

   task automatic test_sw_wait();
      bit          mr[7] = '{1, 1, 1, 0, 0, 1, 1};
      int          st[7] = '{1, 2, 3, 6, 6, 6, 1};
      logic [14:0] v[7]  = '{V_F1, V_DEC, V_MADR, V_MWR, V_MWR, V_MWR, V_F1};
      Opcode = 6'b101011;
      for (int i = 0; i < 7; i++) begin
         if (i > 0) step();
         MemReady = mr[i];
         #1;
         checks++;
         if ({State, outs} !== {st[i][3:0], v[i]}) begin
            errors++;
            $display("FAIL sw_wait[%0d]: state=%0d outs=%b want state=%0d outs=%b",
                     i, State, outs, st[i], v[i]);
         end
      end
   endtask

   task automatic test_rtype();
      int          st[5] = '{1, 2, 7, 8, 1};
      logic [14:0] v[5]  = '{V_F1, V_DEC, V_EXEC, V_AWB, V_F1};
      Opcode = 6'b000000;
      MemReady = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) step();
         #1;
         checks++;
         if ({State, outs} !== {st[i][3:0], v[i]}) begin
            errors++;
            $display("FAIL rtype[%0d]: state=%0d outs=%b want state=%0d outs=%b",
                     i, State, outs, st[i], v[i]);
         end
      end
   endtask

   task automatic test_addi();
      int          st[5] = '{1, 2, 10, 11, 1};
      logic [14:0] v[5]  = '{V_F1, V_DEC, V_MADR, V_IWB, V_F1};
      Opcode = 6'b001000;
      MemReady = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) step();
         #1;
         checks++;
         if ({State, outs} !== {st[i][3:0], v[i]}) begin
            errors++;
            $display("FAIL addi[%0d]: state=%0d outs=%b want state=%0d outs=%b",
                     i, State, outs, st[i], v[i]);
         end
      end
   endtask

   task automatic test_jump();
      int          st[4] = '{1, 2, 12, 1};
      logic [14:0] v[4]  = '{V_F1, V_DEC, V_JMP, V_F1};
      Opcode = 6'b000010;
      MemReady = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) step();
         #1;
         checks++;
         if ({State, outs} !== {st[i][3:0], v[i]}) begin
            errors++;
            $display("FAIL jump[%0d]: state=%0d outs=%b want state=%0d outs=%b",
                     i, State, outs, st[i], v[i]);
         end
      end
   endtask

   task automatic test_beq(input logic z);
      int          st[4] = '{1, 2, 9, 1};
      logic [14:0] v[4]  = '{V_F1, V_DEC, V_BR0, V_F1};
      v[2] = z ? V_BR1 : V_BR0;
      Opcode = 6'b000100;
      Zero = z;
      MemReady = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) step();
         #1;
         checks++;
         if ({State, outs} !== {st[i][3:0], v[i]}) begin
            errors++;
            $display("FAIL beq_z%0d[%0d]: state=%0d outs=%b want state=%0d outs=%b",
                     z, i, State, outs, st[i], v[i]);
         end
      end
      Zero = 1'b0;
   endtask

   task automatic test_illegal();
      int          st[4] = '{1, 2, 1, 2};
      logic [14:0] v[4]  = '{V_F1, V_DECI, V_F1, V_DECI};
      Opcode = 6'b111111;
      MemReady = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) step();
         #1;
         checks++;
         if ({State, outs} !== {st[i][3:0], v[i]}) begin
            errors++;
            $display("FAIL illegal[%0d]: state=%0d outs=%b want state=%0d outs=%b",
                     i, State, outs, st[i], v[i]);
         end
      end
      step();
   endtask

   task automatic test_bne();
`ifdef CTRL_BNE_EN
      int          st[4] = '{1, 2, 9, 1};
      logic [14:0] v[4]  = '{V_F1, V_DEC, V_BR1, V_F1};
`else
      int          st[4] = '{1, 2, 1, 2};
      logic [14:0] v[4]  = '{V_F1, V_DECI, V_F1, V_DECI};
`endif
      Opcode = 6'b000101;
      Zero = 1'b0;
      MemReady = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) step();
         #1;
         checks++;
         if ({State, outs} !== {st[i][3:0], v[i]}) begin
            errors++;
            $display("FAIL bne[%0d]: state=%0d outs=%b want state=%0d outs=%b",
                     i, State, outs, st[i], v[i]);
         end
      end
`ifndef CTRL_BNE_EN
      step();
`endif
   endtask

   task automatic test_async_reset();
      bit          mr[5] = '{1, 1, 0, 0, 0};
      int          st[5] = '{1, 2, 3, 4, 4};
      logic [14:0] v[5]  = '{V_F1, V_DEC, V_MADR, V_MRD, V_MRD};
      Opcode = 6'b100011;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) step();
         MemReady = mr[i];
         #1;
         checks++;
         if ({State, outs} !== {st[i][3:0], v[i]}) begin
            errors++;
            $display("FAIL async_pre[%0d]: state=%0d outs=%b want state=%0d outs=%b",
                     i, State, outs, st[i], v[i]);
         end
      end
      reset = 1'b0;
      #1;
      checks++;
      if ({State, outs} !== {4'd0, V_ZERO}) begin
         errors++;
         $display("FAIL async_reset_now: state=%0d outs=%b want state=0 outs=%b",
                  State, outs, V_ZERO);
      end
      MemReady = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if ({State, MemWrite, RegWrite} !== {4'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_hold[%0d]: state=%0d mw=%b rw=%b want state=0 mw=0 rw=0",
                     i, State, MemWrite, RegWrite);
         end
      end
      @(negedge clk);
      reset = 1'b1;
      step();
      checks++;
      if ({State, outs} !== {4'd1, V_F1}) begin
         errors++;
         $display("FAIL async_recover: state=%0d outs=%b want state=1 outs=%b",
                  State, outs, V_F1);
      end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_sw_wait();
      test_rtype();
      test_addi();
      test_jump();
      test_beq(1'b1);
      test_beq(1'b0);
      test_illegal();
      test_bne();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Moore control FSM for the multicycle MIPS datapath.
- Drives the select lines of the datapath 2-to-1 muxes (IorD, RegDst, MemtoReg, ALUSrcA) and the wider PC/ALU selects, plus all datapath write enables.
- Sits directly upstream of those muxes.
- Sequences fetch/decode/execute per opcode and stalls on a memory-ready handshake.

Parameters:
- OPW, 6, opcode field width
- SW, 4, state register width

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- Opcode  input  OPW  instruction opcode from the IR; stable from DECODE until the instruction returns to FETCH
- Zero  input  1  ALU zero flag
- MemReady  input  1  memory access completes this cycle
- PCEn  output  1  PC register write enable
- IorD  output  1  memory address mux select; 0=PC, 1=ALUOut
- MemWrite  output  1  memory write strobe
- IRWrite  output  1  instruction register load
- RegDst  output  1  write-register mux select; 0=rt, 1=rd
- MemtoReg  output  1  write-data mux select; 0=ALUOut, 1=MDR
- RegWrite  output  1  register file write
- ALUSrcA  output  1  ALU A mux select; 0=PC, 1=A
- ALUSrcB  output  2  ALU B select; 00=B, 01=4, 10=SignImm, 11=SignImm<<2
- ALUOp  output  2  00=add, 01=sub, 10=funct
- PCSrc  output  2  00=ALUResult, 01=ALUOut, 10=jump target
- IllegalOp  output  1  one-cycle pulse in DECODE on an unsupported opcode
- State  output  SW  current state, for debug

Behaviour:
- Reset is asynchronous and active-low: reset=0 forces state to IDLE immediately, regardless of clk.
- All outputs are decoded combinationally from the state register; no output is registered.
- State encodings: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, ADDIEX=10, ADDIWB=11, JUMP=12.
- Codes 13-15 are illegal and go to FETCH on the next edge.
- IDLE: all outputs 0. Next state is FETCH. IDLE therefore lasts exactly one cycle after reset release, and every output is 0 while in reset.
- FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
  - IRWrite=MemReady and PCEn=MemReady.
  - Stay in FETCH while MemReady=0; go to DECODE when MemReady=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by opcode:
  - 100011 (lw) -> MEMADR
  - 101011 (sw) -> MEMADR
  - 000000 (R-type) -> EXEC
  - 000100 (beq) -> BRANCH
  - 001000 (addi) -> ADDIEX
  - 000010 (j) -> JUMP
  - anything else -> FETCH, with IllegalOp=1 for this cycle
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD: IorD=1. Hold while MemReady=0; go to MEMWB when MemReady=1.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Next state is FETCH.
- MEMWR: IorD=1, MemWrite=1 held throughout the state. Hold while MemReady=0; go to FETCH when MemReady=1.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state is ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1. Next state is FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, PCEn=Zero. Next state is FETCH.
- ADDIEX: same selects as MEMADR. Next state is ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1. Next state is FETCH.
- JUMP: PCSrc=10, PCEn=1. Next state is FETCH.
- Every select not listed for a state is 0.
- Cycle counts from FETCH entry, zero wait states: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2. Each cycle of MemReady=0 adds one cycle.

Optional Feature:
- Macro CTRL_BNE_EN.
- Defined: opcode 000101 (bne) goes from DECODE to BRANCH and does not raise IllegalOp. In BRANCH, PCEn = Zero XOR (Opcode==000101).
- Undefined: opcode 000101 is illegal and BRANCH uses PCEn = Zero.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state enum (SW bits)
  - opcode localparams
  - ALUSrcB, ALUOp and PCSrc encoding constants
- One natural sub-module: multicycle_ctrl_decode, a purely combinational state-to-outputs decoder. The top keeps the state register and next-state logic.

Test Plan:
- Reset and release: hold reset=0 for 3 cycles -> all outputs 0 and State=0; after release, State goes 0 then 1.
- lw with MemReady=1 throughout -> States 1,2,3,4,5 then back to 1; RegWrite=1 and MemtoReg=1 only in state 5.
- sw with MemReady=0 for 2 cycles in MEMWR -> MemWrite=1 for 3 cycles, IorD=1, then FETCH.
- beq with Zero=1 -> PCEn=1 and PCSrc=01 in BRANCH. Repeat with Zero=0 -> PCEn=0.
- Opcode 111111 -> IllegalOp=1 for one cycle in DECODE, then FETCH; no RegWrite or MemWrite ever asserted.
- reset=0 asserted mid-MEMRD with MemReady=0 -> State=0 immediately (asynchronous, not waiting for clk); no further MemWrite or RegWrite.
